// File: rtl/inst_rom_responder_pkg.sv
// Shared types and constants for the instruction ROM responder.
package inst_rom_responder_pkg;

  localparam int unsigned BUS_WIDTH = 32;

  typedef enum logic [1:0] {
    RESP_IDLE = 2'd0,
    RESP_READ = 2'd1,
    RESP_RESP = 2'd2
  } resp_state_e;

endpackage

// File: rtl/inst_rom_responder_fifo.sv
// In-order address queue: registered push/pop with a synchronous clear.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_dout  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full && !i_clear;
  assign w_pop   = i_pop && !o_empty && !i_clear;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/inst_rom_responder.sv
// Memory-side responder for instruction fetch: queues accepted addresses, reads the
// synchronous SRAM with optional wait states and returns words in acceptance order.
module inst_rom_responder
  import inst_rom_responder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned ROM_AW      = 12,
  parameter int unsigned DATA_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rom_req,
  input  logic [BUS_WIDTH-1:0] rom_address,
  output logic                 mem_addr_ok,
  input  logic                 flush,
  output logic                 mem_data_ok,
  input  logic                 resp_ready,
  output logic [DATA_W-1:0]    rom_rdata,
  output logic [BUS_WIDTH-1:0] resp_addr,
  output logic                 sram_en,
  output logic [ROM_AW-1:0]    sram_addr,
  input  logic [DATA_W-1:0]    sram_rdata
);

  resp_state_e          r_state;
  resp_state_e          w_state_nxt;
  logic [3:0]           r_wait_cnt;
  logic [3:0]           w_wait_nxt;
  logic [BUS_WIDTH-1:0] r_cur_addr;
  logic [BUS_WIDTH-1:0] r_resp_addr;
  logic [ROM_AW-1:0]    r_sram_addr;
  logic [DATA_W-1:0]    r_rdata;
  logic [BUS_WIDTH-1:0] w_head;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_issue;
  logic                 w_capture;

  assign mem_addr_ok = !w_full && !flush;
  assign w_push      = rom_req && mem_addr_ok;
  assign mem_data_ok = (r_state == RESP_RESP);
  assign rom_rdata   = r_rdata;
  assign resp_addr   = r_resp_addr;

  sync_fifo #(
    .WIDTH (BUS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_addr_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_issue),
    .i_clear (flush),
    .i_din   (rom_address),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_issue     = 1'b0;
    w_capture   = 1'b0;
    if (flush) begin
      w_state_nxt = RESP_IDLE;
    end else begin
      case (r_state)
        RESP_IDLE: begin
          if (!w_empty) begin
            w_issue     = 1'b1;
            w_wait_nxt  = 4'(WAIT_STATES);
            w_state_nxt = RESP_READ;
          end
        end
        RESP_READ: begin
          if (r_wait_cnt != '0) begin
            w_wait_nxt = r_wait_cnt - 4'd1;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = RESP_RESP;
          end
        end
        RESP_RESP: begin
          if (resp_ready) begin
            if (!w_empty) begin
              w_issue     = 1'b1;
              w_wait_nxt  = 4'(WAIT_STATES);
              w_state_nxt = RESP_READ;
            end else begin
              w_state_nxt = RESP_IDLE;
            end
          end
        end
        default: w_state_nxt = RESP_IDLE;
      endcase
    end
  end

  // Enable covers the issue cycle plus the wait cycles; data is sampled once the count expires.
  assign sram_en   = w_issue || (!flush && (r_state == RESP_READ) && (r_wait_cnt != '0));
  assign sram_addr = w_issue ? w_head[ROM_AW+1:2] : r_sram_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RESP_IDLE;
      r_wait_cnt  <= '0;
      r_cur_addr  <= '0;
      r_resp_addr <= '0;
      r_sram_addr <= '0;
      r_rdata     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_issue) begin
        r_sram_addr <= w_head[ROM_AW+1:2];
        r_cur_addr  <= w_head;
      end
      if (w_capture) begin
        r_rdata     <= sram_rdata;
        r_resp_addr <= r_cur_addr;
      end
    end
  end

endmodule

// File: tb/tb_inst_rom_responder.sv
// Directed bench for inst_rom_responder: one instance with no wait states, one with three.
module tb_inst_rom_responder;
  import inst_rom_responder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req, flush, rdy, sel;
  logic [31:0] addr;

  logic        ok0, dok0, en0, ok3, dok3, en3;
  logic [31:0] rd0, ra0, rd3, ra3;
  logic [11:0] sa0, sa3;
  logic [31:0] srd0 = '0;
  logic [31:0] srd3 = '0;

  logic        ok, dok, en;
  logic [31:0] rd, ra;
  logic [11:0] sa;

  function automatic logic [31:0] word(input logic [11:0] a);
    return {4'hA, a, 4'h5, a};
  endfunction

  always @(posedge clk) if (en0) srd0 <= word(sa0);
  always @(posedge clk) if (en3) srd3 <= word(sa3);

  assign ok  = sel ? ok3  : ok0;
  assign dok = sel ? dok3 : dok0;
  assign en  = sel ? en3  : en0;
  assign rd  = sel ? rd3  : rd0;
  assign ra  = sel ? ra3  : ra0;
  assign sa  = sel ? sa3  : sa0;

  inst_rom_responder #(.FIFO_DEPTH(4), .WAIT_STATES(0), .ROM_AW(12), .DATA_W(32)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rom_req(req & ~sel), .rom_address(addr), .mem_addr_ok(ok0),
    .flush(flush & ~sel), .mem_data_ok(dok0), .resp_ready(rdy & ~sel), .rom_rdata(rd0),
    .resp_addr(ra0), .sram_en(en0), .sram_addr(sa0), .sram_rdata(srd0));

  inst_rom_responder #(.FIFO_DEPTH(4), .WAIT_STATES(3), .ROM_AW(12), .DATA_W(32)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .rom_req(req & sel), .rom_address(addr), .mem_addr_ok(ok3),
    .flush(flush & sel), .mem_data_ok(dok3), .resp_ready(rdy & sel), .rom_rdata(rd3),
    .resp_addr(ra3), .sram_en(en3), .sram_addr(sa3), .sram_rdata(srd3));

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  logic [31:0] bp_addr [6];
  int acc, got, extra, first, en_cnt, sa_bad;

  initial begin
    rst_n = 1'b0; req = 1'b0; addr = '0; flush = 1'b0; rdy = 1'b0; sel = 1'b0;
    repeat (2) samp();
    check("rst_data_ok", dok, 0);
    check("rst_sram_en", en, 0);
    check("rst_rdata", rd, 0);
    check("rst_resp_addr", ra, 0);
    check("rst_sram_addr", sa, 0);

    // single fetch, no wait states
    @(posedge clk); #1;
    rst_n = 1'b1; req = 1'b1; addr = 32'h100;
    samp(); check("t1_addr_ok", ok, 1);
    tick(); req = 1'b0;
    samp(); check("t1_en", en, 1); check("t1_saddr", sa, 12'h40); check("t1_dok_t1", dok, 0);
    tick(); samp(); check("t1_dok_t2", dok, 0); check("t1_en_t2", en, 0);
    tick(); rdy = 1'b1;
    samp(); check("t1_dok_t3", dok, 1); check("t1_raddr", ra, 32'h100); check("t1_rdata", rd, word(12'h40));
    tick(); rdy = 1'b0;
    samp(); check("t1_dok_after", dok, 0);

    // back-pressure
    for (int k = 0; k < 6; k++) bp_addr[k] = 32'h1000 + 32'(4 * k);
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      tick(); req = 1'b1; addr = bp_addr[acc];
      samp(); if (ok) acc++;
    end
    check("bp_accepted", acc, 5);
    check("bp_addr_ok_low", ok, 0);
    got = 0;
    for (int i = 0; i < 100 && got < 6; i++) begin
      tick(); rdy = 1'b1; req = (acc < 6);
      if (acc < 6) addr = bp_addr[acc];
      samp();
      if (req && ok) acc++;
      if (dok) begin
        check("bp_raddr", ra, bp_addr[got]);
        check("bp_rdata", rd, word(bp_addr[got][13:2]));
        got++;
      end
    end
    check("bp_resp_count", got, 6);
    check("bp_accept_all", acc, 6);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick(); req = 1'b0; samp(); if (dok) extra++;
    end
    check("bp_no_dup", extra, 0);
    tick(); rdy = 1'b0;

    // three wait states
    sel = 1'b1; req = 1'b1; addr = 32'h8;
    samp(); check("ws_addr_ok", ok, 1);
    en_cnt = 0; sa_bad = 0; first = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(); req = 1'b0; samp();
      if (en) begin en_cnt++; if (sa != 12'h2) sa_bad++; end
      if (dok && first == 0) first = i;
    end
    check("ws_en_cycles", en_cnt, 4);
    check("ws_saddr_bad", sa_bad, 0);
    check("ws_latency", first, 6);
    check("ws_raddr", ra, 32'h8);
    check("ws_rdata", rd, word(12'h2));
    tick(); rdy = 1'b1; samp();
    tick(); rdy = 1'b0; samp(); check("ws_dok_after", dok, 0);

    // flush while reading with two queued entries
    tick(); req = 1'b1; addr = 32'h500; samp();
    tick(); addr = 32'h504; samp();
    tick(); addr = 32'h508; samp();
    tick(); req = 1'b0; flush = 1'b1;
    samp(); check("fl_addr_ok", ok, 0);
    tick(); flush = 1'b0;
    samp(); check("fl_dok", dok, 0); check("fl_en", en, 0); check("fl_addr_ok_after", ok, 1);
    tick(); req = 1'b1; addr = 32'h200; samp();
    first = 0; got = 0;
    for (int i = 1; i <= 12; i++) begin
      tick(); req = 1'b0; rdy = 1'b0; samp();
      if (dok && first == 0) first = i;
    end
    check("fl_latency", first, 6);
    check("fl_raddr", ra, 32'h200);
    check("fl_rdata", rd, word(12'h80));
    tick(); rdy = 1'b1; samp();
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick(); samp(); if (dok) extra++;
    end
    check("fl_no_stale", extra, 0);
    tick(); rdy = 1'b0;

    // flush coinciding with a response handshake
    sel = 1'b0; req = 1'b1; addr = 32'h600; samp();
    tick(); addr = 32'h604; samp();
    tick(); req = 1'b0; samp();
    tick(); rdy = 1'b1; flush = 1'b1;
    samp(); check("fh_dok", dok, 1); check("fh_raddr", ra, 32'h600);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); flush = 1'b0; samp(); if (dok || en) extra++;
    end
    check("fh_nothing_more", extra, 0);
    tick(); rdy = 1'b0;

    // reset mid-stream, then an aliased address
    req = 1'b1; addr = 32'h300; samp();
    tick(); req = 1'b0; samp();
    tick(); samp();
    tick(); samp(); check("rm_dok_before", dok, 1);
    #1 rst_n = 1'b0;
    #1 check("rm_dok_async", dok, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; req = 1'b1; addr = 32'h4000;
    samp(); check("rm_addr_ok", ok, 1); check("rm_dok_release", dok, 0);
    tick(); req = 1'b0;
    samp(); check("rm_en", en, 1); check("rm_saddr_alias", sa, 12'h0);
    first = 0;
    for (int i = 2; i <= 10; i++) begin
      tick(); samp(); if (dok && first == 0) first = i;
    end
    check("rm_latency", first, 3);
    check("rm_raddr", ra, 32'h4000);
    check("rm_rdata", rd, word(12'h0));
    tick(); rdy = 1'b1; samp();
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick(); samp(); if (dok) extra++;
    end
    check("rm_no_old_resp", extra, 0);
    rdy = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
